bin2seg_converter: RTL and testbench
====================================

# bin2seg_converter

- Sequential binary-to-two-digit seven-segment encoder.
- Sits directly upstream of the display scan controller and drives its `seg_0` (ones) and `seg_1` (tens) pattern inputs.
- Accepts a 7-bit binary value on a load strobe and converts it to BCD with a multi-cycle shift-add-3 (double-dabble) engine.
- Registers the two segment patterns and signals completion with a one-cycle `done` pulse.

## Interface
Parameters:
- none (width fixed at 7 bits; display range 0..99)

Ports:
- `clk`  in  1  system clock; all state updates on rising edge
- `rst_x`  in  1  asynchronous, active-low reset
- `load`  in  1  start strobe; sampled only in IDLE
- `bin_in`  in  7  unsigned binary value, captured on accepted `load`
- `seg_0`  out  7  ones-digit pattern; bit0=a … bit6=g; 1 = segment lit
- `seg_1`  out  7  tens-digit pattern; same encoding
- `busy`  out  1  high while a conversion is in progress
- `done`  out  1  one-cycle pulse when `seg_0`/`seg_1` update
- `ovf`  out  1  last completed conversion had `bin_in` > 99

## Operation
- **FSM states:** IDLE, SHIFT, UPDATE.
- **IDLE:**
  - `load`=1 captures `bin_in` into a 7-bit shift register.
  - Clears the 8-bit BCD register (tens[7:4], ones[3:0]) and the 3-bit shift counter.
  - Latches an overflow flag = (`bin_in` > 99). Next state is SHIFT.
- **SHIFT:** once per cycle:
  - First, add 3 to each BCD nibble that is ≥5.
  - Then shift {BCD, shift register} left by 1.
  - Increment the counter. After the 7th shift, go to UPDATE.
  - Nibble adjust uses 4-bit arithmetic. Values ≤99 never carry out of the tens nibble. Bits shifted out of the tens nibble for inputs >99 are discarded.
- **UPDATE:**
  - Overflow flag set: `seg_0` = `seg_1` = 7'b1000000 (dash), `ovf`←1.
  - Otherwise: encode nibbles and set `ovf`←0.
  - Assert `done` for one cycle, then go to IDLE.
- **Digit encoding (g..a):**
  - 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110
  - 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111
- **Busy and output hold:**
  - `busy` = (state ≠ IDLE).
  - `load` while busy is ignored: no queuing, no error flag.
  - `seg_0`, `seg_1` and `ovf` hold their values between UPDATEs. The downstream scanner sees only completed results, never intermediate values.
- **Reset (any state, including mid-conversion):**
  - State → IDLE; `seg_0` = `seg_1` = 7'b0000000 (blank).
  - `busy`=0, `done`=0, `ovf`=0; the in-flight conversion is discarded.

## Timing
- `load` accepted at edge E0 → `busy`=1 after E0.
- Shifts occur on E1..E7; UPDATE executes on E8.
- After E8, `seg_*`/`ovf` are updated, `done`=1 for exactly one cycle, and `busy`=0.
- Latency from accepted `load` to new outputs: 8 clocks.
- A `load` in the cycle where `done`=1 (state IDLE) is accepted. Back-to-back throughput is one conversion per 9 clocks.
- `bin_in` is sampled only at the accepting edge; later changes have no effect.
- All outputs are registered; no combinational path from inputs to outputs.

## Configuration
- **Macro `LEADING_ZERO_BLANK_EN`:**
  - Defined: a non-overflow result with tens nibble 0 gives `seg_1` = 7'b0000000 (blank).
  - Undefined: `seg_1` shows the digit-0 pattern 7'b0111111.
- `seg_0` always shows its digit, including 0.
- Overflow dash display is unaffected by the macro.

## Test plan
- Reset asserted → `seg_0`=`seg_1`=0000000, `busy`=0, `done`=0, `ovf`=0. Release, no `load` → outputs unchanged for 20 cycles.
- `load`=1, `bin_in`=42 → `busy` high 8 cycles, `done` pulse 8 clocks after accept; `seg_1`=1100110, `seg_0`=1011011, `ovf`=0.
- `bin_in`=7:
  - Macro undefined → `seg_1`=0111111, `seg_0`=0000111.
  - Macro defined → `seg_1`=0000000.
- `bin_in`=99 → both digits 1101111. Then `bin_in`=100 → both digits 1000000, `ovf`=1. Then `bin_in`=0 → `ovf`=0, `seg_0`=0111111.
- Accept `bin_in`=15, then pulse `load` with `bin_in`=88 at cycles 3 and 7 of busy → single `done`, result 15 (0000110 / 1101101). `load` with 88 during the `done` cycle → accepted, result 88 after 8 clocks.
- Load 57, then assert `rst_x` low at cycle 4 → immediate blank outputs, `busy`=0, no `done` after release. A subsequent load of 63 converts correctly.

Source files
------------

// File: rtl/bin2seg_if.sv
// bin2seg_if: load/result bundle between a binary-value source, the
// bin2seg_converter and the display scan controller that consumes seg_0/seg_1.
interface bin2seg_if;
    logic       load;
    logic [6:0] bin_in;
    logic [6:0] seg_0;
    logic [6:0] seg_1;
    logic       busy;
    logic       done;
    logic       ovf;

    // Value source / test driver side
    modport master (
        output load,
        output bin_in,
        input  seg_0,
        input  seg_1,
        input  busy,
        input  done,
        input  ovf
    );

    // Converter side
    modport slave (
        input  load,
        input  bin_in,
        output seg_0,
        output seg_1,
        output busy,
        output done,
        output ovf
    );
endinterface

// File: rtl/bin2seg_converter.sv
// bin2seg_converter: sequential 7-bit binary to two-digit seven-segment encoder.
// A load in IDLE starts a 7-step shift-add-3 (double-dabble) conversion; the
// UPDATE step registers both segment patterns and pulses done for one cycle.
// Values above 99 display a dash on both digits and raise ovf.
// Optional build macro: LEADING_ZERO_BLANK_EN blanks a zero tens digit.
module bin2seg_converter (
    input  logic      clk,
    input  logic      rst_x,
    bin2seg_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        UPDATE = 2'd2
    } state_t;

    localparam logic [6:0] SEG_BLANK = 7'b0000000;
    localparam logic [6:0] SEG_DASH  = 7'b1000000;
    localparam logic [6:0] SEG_ZERO  = 7'b0111111;

    state_t     r_state;
    state_t     w_next;

    logic [6:0] r_sh;
    logic [7:0] r_bcd;
    logic [2:0] r_cnt;
    logic       r_ovf_pend;

    logic [6:0] r_seg0;
    logic [6:0] r_seg1;
    logic       r_ovf;
    logic       r_done;
    logic       r_busy;

    logic       w_accept;
    logic       w_last;
    logic [7:0] w_bcd_adj;
    logic [6:0] w_seg0_dig;
    logic [6:0] w_seg1_dig;

    // Add 3 to a BCD nibble that would exceed 9 after the next doubling.
    function automatic logic [3:0] adj_nibble(input logic [3:0] n);
        if (n >= 4'd5)
            return n + 4'd3;
        else
            return n;
    endfunction

    // Segment pattern for one decimal digit, bit0=a .. bit6=g, 1 = lit.
    function automatic logic [6:0] enc_digit(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b0111111;
            4'd1:    s = 7'b0000110;
            4'd2:    s = 7'b1011011;
            4'd3:    s = 7'b1001111;
            4'd4:    s = 7'b1100110;
            4'd5:    s = 7'b1101101;
            4'd6:    s = 7'b1111101;
            4'd7:    s = 7'b0000111;
            4'd8:    s = 7'b1111111;
            4'd9:    s = 7'b1101111;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    assign w_accept  = (r_state == IDLE) && bus.load;
    assign w_last    = (r_cnt == 3'd6);
    assign w_bcd_adj = {adj_nibble(r_bcd[7:4]), adj_nibble(r_bcd[3:0])};

    assign w_seg0_dig = enc_digit(r_bcd[3:0]);
`ifdef LEADING_ZERO_BLANK_EN
    assign w_seg1_dig = (r_bcd[7:4] == 4'd0) ? SEG_BLANK : enc_digit(r_bcd[7:4]);
`else
    assign w_seg1_dig = enc_digit(r_bcd[7:4]);
`endif

    // State register; reset abandons any conversion in flight.
    always_ff @(posedge clk or negedge rst_x) begin
        if (!rst_x)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    // Next-state logic: IDLE -> SHIFT on load, seven shifts, one UPDATE.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (bus.load) w_next = SHIFT;
            SHIFT:   if (w_last)   w_next = UPDATE;
            UPDATE:  w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Conversion datapath: capture on accept, adjust-then-shift each SHIFT cycle.
    // The tens carry-out is dropped by the 8-bit truncation of the shift.
    always_ff @(posedge clk or negedge rst_x) begin
        if (!rst_x) begin
            r_sh       <= '0;
            r_bcd      <= '0;
            r_cnt      <= '0;
            r_ovf_pend <= 1'b0;
        end else if (w_accept) begin
            r_sh       <= bus.bin_in;
            r_bcd      <= '0;
            r_cnt      <= '0;
            r_ovf_pend <= (bus.bin_in > 7'd99);
        end else if (r_state == SHIFT) begin
            r_bcd <= (w_bcd_adj << 1) | {7'b0, r_sh[6]};
            r_sh  <= r_sh << 1;
            r_cnt <= r_cnt + 3'd1;
        end
    end

    // Result registers: only UPDATE touches them, so the scanner never sees partials.
    always_ff @(posedge clk or negedge rst_x) begin
        if (!rst_x) begin
            r_seg0 <= SEG_BLANK;
            r_seg1 <= SEG_BLANK;
            r_ovf  <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= (r_state == UPDATE);
            if (r_state == UPDATE) begin
                if (r_ovf_pend) begin
                    r_seg0 <= SEG_DASH;
                    r_seg1 <= SEG_DASH;
                    r_ovf  <= 1'b1;
                end else begin
                    r_seg0 <= w_seg0_dig;
                    r_seg1 <= w_seg1_dig;
                    r_ovf  <= 1'b0;
                end
            end
        end
    end

    // Registered busy flag mirrors "next state is not IDLE".
    always_ff @(posedge clk or negedge rst_x) begin
        if (!rst_x)
            r_busy <= 1'b0;
        else
            r_busy <= (w_next != IDLE);
    end

    assign bus.seg_0 = r_seg0;
    assign bus.seg_1 = r_seg1;
    assign bus.ovf   = r_ovf;
    assign bus.done  = r_done;
    assign bus.busy  = r_busy;

endmodule

// File: tb/tb_bin2seg_converter.sv
// Directed bench for bin2seg_converter with a scoreboard of expected displays.
module tb_bin2seg_converter;

    typedef struct packed {
        logic [6:0] s0;
        logic [6:0] s1;
        logic       ovf;
    } exp_t;

    logic clk = 1'b0;
    logic rst_x = 1'b0;
    int   total = 0;
    int   bad   = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    bin2seg_if bus ();

    bin2seg_converter dut (
        .clk   (clk),
        .rst_x (rst_x),
        .bus   (bus.slave)
    );

    function automatic logic [6:0] digit(input int d);
        logic [6:0] tbl [10];
        tbl = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110,
                7'b1101101, 7'b1111101, 7'b0000111, 7'b1111111, 7'b1101111};
        return tbl[d];
    endfunction

    function automatic exp_t model(input int v);
        exp_t e;
        if (v > 99) begin
            e.s0 = 7'b1000000; e.s1 = 7'b1000000; e.ovf = 1'b1;
        end else begin
            e.s0  = digit(v % 10);
            e.s1  = digit(v / 10);
`ifdef LEADING_ZERO_BLANK_EN
            if (v / 10 == 0) e.s1 = 7'b0000000;
`endif
            e.ovf = 1'b0;
        end
        return e;
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive a one-cycle load at a negedge; optionally record the expected result.
    task automatic start(input int v, input bit push);
        bus.load   = 1'b1;
        bus.bin_in = 7'(v);
        if (push) sb.push_back(model(v));
        @(negedge clk);
        bus.load   = 1'b0;
        bus.bin_in = 7'($urandom_range(0, 127));
    endtask

    // Wait for done (bounded), optionally pulsing ignored loads of 88 at busy cycles pa/pb.
    task automatic finish(input int pa, input int pb);
        int   cyc;
        int   busy_cnt;
        exp_t e;
        cyc = 1;
        busy_cnt = 0;
        check("busy_after_accept", 16'(bus.busy), 16'd1);
        while (!bus.done && cyc < 30) begin
            if (bus.busy) busy_cnt++;
            bus.load = (cyc == pa) || (cyc == pb);
            bus.bin_in = bus.load ? 7'd88 : 7'($urandom_range(0, 127));
            @(negedge clk);
            cyc++;
        end
        bus.load = 1'b0;
        check("done_latency", 16'(cyc), 16'd9);
        check("busy_cycles", 16'(busy_cnt), 16'd8);
        check("busy_low_at_done", 16'(bus.busy), 16'd0);
        check("sb_nonempty", 16'(sb.size() != 0), 16'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check("seg_0", 16'(bus.seg_0), 16'(e.s0));
            check("seg_1", 16'(bus.seg_1), 16'(e.s1));
            check("ovf", 16'(bus.ovf), 16'(e.ovf));
        end
    endtask

    task automatic idle_check();
        @(negedge clk);
        check("done_one_cycle", 16'(bus.done), 16'd0);
        check("busy_idle", 16'(bus.busy), 16'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int   dev;
        int   ndone;
        logic [6:0] h0, h1;
        logic       hovf;

        bus.load   = 1'b0;
        bus.bin_in = 7'd0;
        rst_x      = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_seg_0", 16'(bus.seg_0), 16'h0);
        check("rst_seg_1", 16'(bus.seg_1), 16'h0);
        check("rst_busy", 16'(bus.busy), 16'd0);
        check("rst_done", 16'(bus.done), 16'd0);
        check("rst_ovf", 16'(bus.ovf), 16'd0);

        rst_x = 1'b1;
        dev = 0;
        repeat (20) begin
            @(negedge clk);
            if ({bus.seg_0, bus.seg_1, bus.busy, bus.done, bus.ovf} !== 17'd0) dev++;
        end
        check("idle_hold_20", 16'(dev), 16'd0);

        start(42, 1'b1);  finish(0, 0); idle_check();
        start(7, 1'b1);   finish(0, 0); idle_check();
        start(99, 1'b1);  finish(0, 0); idle_check();
        start(100, 1'b1); finish(0, 0); idle_check();

        h0 = bus.seg_0; h1 = bus.seg_1; hovf = bus.ovf;
        repeat (5) @(negedge clk);
        check("hold_seg_0", 16'(bus.seg_0), 16'(h0));
        check("hold_ovf", 16'(bus.ovf), 16'(hovf));

        start(0, 1'b1);   finish(0, 0); idle_check();
        start(19, 1'b1);  finish(0, 0); idle_check();
        start(50, 1'b1);  finish(0, 0); idle_check();
        start(127, 1'b1); finish(0, 0); idle_check();

        // Ignored loads during busy, then a load in the done cycle.
        start(15, 1'b1);  finish(3, 7);
        start(88, 1'b1);  finish(0, 0); idle_check();

        // Reset mid-conversion.
        start(57, 1'b0);
        repeat (3) @(negedge clk);
        rst_x = 1'b0;
        #1;
        check("midrst_seg_0", 16'(bus.seg_0), 16'h0);
        check("midrst_seg_1", 16'(bus.seg_1), 16'h0);
        check("midrst_busy", 16'(bus.busy), 16'd0);
        check("midrst_done", 16'(bus.done), 16'd0);
        check("midrst_ovf", 16'(bus.ovf), 16'd0);
        repeat (2) @(negedge clk);
        rst_x = 1'b1;
        ndone = 0;
        repeat (12) begin
            @(negedge clk);
            if (bus.done) ndone++;
        end
        check("no_done_after_rst", 16'(ndone), 16'd0);

        start(63, 1'b1);  finish(0, 0); idle_check();
        check("sb_drained", 16'(sb.size()), 16'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
